// File: rtl/mc_pkg.sv
// Shared constants for the multicycle controller: opcode/func codes, FSM states,
// ALU operation codes and the datapath control bundle.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] PC_ALU  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JUMP = 2'b10;
    localparam logic [1:0] PC_REG  = 2'b11;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC,
        RWB, IEXEC, IWB, BEQ, JMP, JAL, JR
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       data_c;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    // DECODE dispatch; FETCH here means an unrecognised instruction.
    function automatic state_t decode_next(input logic [5:0] opcode, input logic [5:0] func);
        state_t nxt;
        case (opcode)
            OP_LW, OP_SW:               nxt = MEMADR;
            OP_RTYPE:                   nxt = (func == FN_JR) ? JR : REXEC;
            OP_ADDI, OP_ADDIU, OP_SLTI: nxt = IEXEC;
            OP_BEQ:                     nxt = BEQ;
            OP_J:                       nxt = JMP;
            OP_JAL:                     nxt = JAL;
            default:                    nxt = FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// R-type func field to ALU operation code.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] aluop
);

    always_comb begin
        case (func)
            FN_SUB:  aluop = ALU_SUB;
            FN_SLT:  aluop = ALU_SLT;
            default: aluop = func[2:0];
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM. Define MC_MEM_WAIT_EN to make FETCH, MEMRD
// and MEMWR stall on mem_ready; otherwise each memory state takes one cycle.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       AluSrcA,
    output logic       DataC,
    output logic [1:0] RegDst,
    output logic [1:0] AluSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] AluOperation,
    output logic       InstrDone
);

    state_t     state;
    logic [2:0] alu_func;
    logic [2:0] alu_hold;
    logic       mem_ok;
    ctrl_t      ctrl;

`ifdef MC_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    mc_alu_decode u_alu_decode (
        .func  (func),
        .aluop (alu_func)
    );

    // RWB must keep the op chosen in REXEC even if func moves afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            alu_hold <= '0;
        end else begin
            case (state)
                FETCH:   if (mem_ok) state <= DECODE;
                DECODE:  state <= decode_next(opcode, func);
                MEMADR:  state <= (opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (mem_ok) state <= MEMWB;
                MEMWR:   if (mem_ok) state <= FETCH;
                REXEC: begin
                    state    <= RWB;
                    alu_hold <= alu_func;
                end
                IEXEC:   state <= IWB;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.ir_write  = mem_ok;
                    ctrl.pc_write  = mem_ok;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_source = PC_ALU;
                end
                DECODE: begin
                    ctrl.alu_src_b  = SRCB_BR;
                    ctrl.alu_op     = ALU_ADD;
                    ctrl.instr_done = (decode_next(opcode, func) == FETCH);
                end
                MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_dst    = DST_RT;
                    ctrl.instr_done = 1'b1;
                end
                MEMWR: begin
                    ctrl.mem_write  = 1'b1;
                    ctrl.iord       = 1'b1;
                    ctrl.instr_done = mem_ok;
                end
                REXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = alu_func;
                end
                RWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = DST_RD;
                    ctrl.alu_op     = alu_hold;
                    ctrl.instr_done = 1'b1;
                end
                IEXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                IWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = DST_RT;
                    ctrl.instr_done = 1'b1;
                end
                BEQ: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REG;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PC_BR;
                    ctrl.instr_done    = 1'b1;
                end
                JMP: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_source  = PC_JUMP;
                    ctrl.instr_done = 1'b1;
                end
                JAL: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_source  = PC_JUMP;
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = DST_RA;
                    ctrl.data_c     = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                JR: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_source  = PC_REG;
                    ctrl.instr_done = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign PCWrite      = ctrl.pc_write;
    assign PCWriteCond  = ctrl.pc_write_cond;
    assign IorD         = ctrl.iord;
    assign MemRead      = ctrl.mem_read;
    assign MemWrite     = ctrl.mem_write;
    assign IRWrite      = ctrl.ir_write;
    assign MemtoReg     = ctrl.mem_to_reg;
    assign RegWrite     = ctrl.reg_write;
    assign AluSrcA      = ctrl.alu_src_a;
    assign DataC        = ctrl.data_c;
    assign RegDst       = ctrl.reg_dst;
    assign AluSrcB      = ctrl.alu_src_b;
    assign PCSource     = ctrl.pc_source;
    assign AluOperation = ctrl.alu_op;
    assign InstrDone    = ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle traces built
// from instruction class, with scrambled opcode/func outside the sampling cycles.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, asa, dc;
        logic [1:0] rdst, asb, pcs;
        logic [2:0] aop;
        logic       done;
    } ov_t;

`ifdef MC_MEM_WAIT_EN
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic       RegWrite, AluSrcA, DataC, InstrDone;
    logic [1:0] RegDst, AluSrcB, PCSource;
    logic [2:0] AluOperation;
    ov_t        got;

    int vectors = 0;
    int miscompares = 0;

    ov_t eq[$];
    int  rq[$];   // mem_ready drive: 0, 1, or 2 = random
    bit  sq[$];   // cycle samples opcode/func

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .AluSrcA(AluSrcA), .DataC(DataC), .RegDst(RegDst), .AluSrcB(AluSrcB),
        .PCSource(PCSource), .AluOperation(AluOperation), .InstrDone(InstrDone)
    );

    assign got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegWrite, AluSrcA, DataC, RegDst, AluSrcB, PCSource, AluOperation, InstrDone};

    always #5 clk = ~clk;

    function automatic void push(input ov_t v, input int rdy, input bit smp);
        eq.push_back(v);
        rq.push_back(rdy);
        sq.push_back(smp);
    endfunction

    // Expected per-cycle outputs for one instruction, from its class.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                  input int fstall, input int mstall);
        ov_t v;
        bit is_lw  = (op == 6'd35);
        bit is_sw  = (op == 6'd43);
        bit is_jr  = (op == 6'd0) && (fn == 6'd8);
        bit is_r   = (op == 6'd0) && (fn != 6'd8);
        bit is_imm = (op == 6'd8) || (op == 6'd9) || (op == 6'd10);
        bit is_beq = (op == 6'd4);
        bit is_j   = (op == 6'd2);
        bit is_jal = (op == 6'd3);
        bit legal  = is_lw | is_sw | is_jr | is_r | is_imm | is_beq | is_j | is_jal;
        logic [2:0] ralu = (fn == 6'd34) ? 3'd3 : (fn == 6'd42) ? 3'd4 : fn[2:0];
        eq.delete(); rq.delete(); sq.delete();
        for (int s = 0; s < fstall; s++) begin
            v = '0; v.mrd = 1; v.asb = 2'b01; v.aop = 3'd2;
            push(v, 0, 0);
        end
        v = '0; v.mrd = 1; v.irw = 1; v.pcw = 1; v.asb = 2'b01; v.aop = 3'd2;
        push(v, 1, 0);
        v = '0; v.asb = 2'b11; v.aop = 3'd2; v.done = !legal;
        push(v, 2, 1);
        if (is_lw || is_sw) begin
            v = '0; v.asa = 1; v.asb = 2'b10; v.aop = 3'd2;
            push(v, 2, 1);
            for (int s = 0; s <= mstall; s++) begin
                v = '0; v.iord = 1;
                if (is_lw) v.mrd = 1;
                else begin v.mwr = 1; v.done = (s == mstall); end
                push(v, (s == mstall) ? 1 : 0, 0);
            end
            if (is_lw) begin
                v = '0; v.rw = 1; v.m2r = 1; v.done = 1;
                push(v, 2, 0);
            end
        end else if (is_r) begin
            v = '0; v.asa = 1; v.aop = ralu;
            push(v, 2, 1);
            v = '0; v.rw = 1; v.rdst = 2'b01; v.aop = ralu; v.done = 1;
            push(v, 2, 0);
        end else if (is_imm) begin
            v = '0; v.asa = 1; v.asb = 2'b10; v.aop = (op == 6'd10) ? 3'd4 : 3'd2;
            push(v, 2, 1);
            v = '0; v.rw = 1; v.done = 1;
            push(v, 2, 0);
        end else if (is_beq) begin
            v = '0; v.asa = 1; v.aop = 3'd3; v.pcwc = 1; v.pcs = 2'b01; v.done = 1;
            push(v, 2, 0);
        end else if (is_j || is_jal || is_jr) begin
            v = '0; v.pcw = 1; v.done = 1;
            v.pcs = is_jr ? 2'b11 : 2'b10;
            if (is_jal) begin v.rw = 1; v.rdst = 2'b10; v.dc = 1; end
            push(v, 2, 0);
        end
    endfunction

    // Plays the built trace; stops before cycle abort_at (negative = run all).
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int fstall, input int mstall, input int abort_at);
        build(op, fn, WAIT ? fstall : 0, WAIT ? mstall : 0);
        for (int i = 0; i < eq.size(); i++) begin
            if (i == abort_at) break;
            @(posedge clk); #1;
            rst = 1'b0;
            opcode = sq[i] ? op : 6'($urandom);
            func   = sq[i] ? fn : 6'($urandom);
            mem_ready = (rq[i] == 2 || !WAIT) ? 1'($urandom) : rq[i][0];
            #1;
            vectors++;
            if (got !== eq[i]) begin
                miscompares++;
                $display("FAIL %s op=%b fn=%b cycle %0d: got %h expected %h",
                         name, op, fn, i + 1, got, eq[i]);
            end
        end
    endtask

    task automatic hold_reset(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            opcode = 6'($urandom); func = 6'($urandom); mem_ready = 1'($urandom);
            #1;
            vectors++;
            if (got !== ov_t'(0)) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h expected 0", name, i, got);
            end
        end
    endtask

    task automatic test_reset();
        hold_reset("reset", 3);
        run_instr("post_reset_fetch", 6'd2, 6'd0, 0, 0, -1);
    endtask

    task automatic test_lw();       run_instr("lw", 6'd35, 6'($urandom), 0, 0, -1); endtask
    task automatic test_rtype_sub(); run_instr("sub", 6'd0, 6'd34, 0, 0, -1); endtask
    task automatic test_jal();      run_instr("jal", 6'd3, 6'($urandom), 0, 0, -1); endtask
    task automatic test_illegal();  run_instr("illegal", 6'd63, 6'($urandom), 0, 0, -1); endtask

    task automatic test_reset_mid();
        run_instr("lw_abort", 6'd35, 6'd0, 0, 0, 3);
        hold_reset("reset_in_memrd", 2);
        run_instr("after_mid_reset", 6'd43, 6'd0, 0, 0, -1);
    endtask

    task automatic test_mem_wait();
        run_instr("sw_wait", 6'd43, 6'($urandom), 0, 3, -1);
        run_instr("lw_wait", 6'd35, 6'($urandom), 2, 2, -1);
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        for (int n = 0; n < 60; n++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 12))
                0: op = 6'd35;  1: op = 6'd43;  2: op = 6'd0;
                3: begin op = 6'd0; fn = 6'd34; end
                4: begin op = 6'd0; fn = 6'd42; end
                5: begin op = 6'd0; fn = 6'd8; end
                6: op = 6'd8;   7: op = 6'd9;   8: op = 6'd10;
                9: op = 6'd4;   10: op = 6'd2;  11: op = 6'd3;
                default: op = 6'($urandom);
            endcase
            run_instr("random", op, fn, $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_beq", 6'd4, 6'd0, 0, 0, -1);
        run_instr("b2b_slti", 6'd10, 6'd0, 0, 0, -1);
        run_instr("b2b_jr", 6'd0, 6'd8, 0, 0, -1);
        run_instr("b2b_slt", 6'd0, 6'd42, 0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_sub();
        test_jal();
        test_illegal();
        test_reset_mid();
        if (WAIT) test_mem_wait();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
